// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
//   In-order write-back queue feeding the register file write port (A3/WD3/WE3).
//   Producers of any latency push (addr, data) requests; one entry drains per
//   cycle in which the register file grants its write port. Two lookup ports
//   report the youngest still-pending write to a register so decode can forward
//   results that have not reached the register file yet.
//
// Ports
//   CLK        clock, all state on rising edge
//   RST        asynchronous active-low reset
//   In_Valid   producer offers a write request
//   In_Ready   queue can accept (not full)
//   In_Addr    destination register index
//   In_Data    write data
//   WB_Grant   register file write port available this cycle
//   WE3        write enable to register file
//   A3         write address to register file
//   WD3        write data to register file
//   LK_A1/2    lookup addresses
//   LK_Hit1/2  a pending write to LK_A1/2 exists
//   LK_D1/2    data of the youngest pending write to LK_A1/2 (0 on miss)
//   Count      occupied entries

module regfile_wb_queue #(
    parameter int unsigned Address_Width       = 5,
    parameter int unsigned Register_File_Width = 32,
    parameter int unsigned Queue_Depth         = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             In_Valid,
    output logic                             In_Ready,
    input  logic [Address_Width-1:0]         In_Addr,
    input  logic [Register_File_Width-1:0]   In_Data,
    input  logic                             WB_Grant,
    output logic                             WE3,
    output logic [Address_Width-1:0]         A3,
    output logic [Register_File_Width-1:0]   WD3,
    input  logic [Address_Width-1:0]         LK_A1,
    input  logic [Address_Width-1:0]         LK_A2,
    output logic                             LK_Hit1,
    output logic                             LK_Hit2,
    output logic [Register_File_Width-1:0]   LK_D1,
    output logic [Register_File_Width-1:0]   LK_D2,
    output logic [$clog2(Queue_Depth):0]     Count
);

    localparam int unsigned IdxW = $clog2(Queue_Depth);
    localparam int unsigned PtrW = IdxW + 1;

    // Storage
    logic [Address_Width-1:0]       addr_q  [Queue_Depth];
    logic [Register_File_Width-1:0] data_q  [Queue_Depth];
    logic [Queue_Depth-1:0]         valid_q;
    logic [Queue_Depth-1:0]         valid_d;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rd_idx;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign wr_idx = wr_ptr_q[IdxW-1:0];
    assign rd_idx = rd_ptr_q[IdxW-1:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) && (wr_idx == rd_idx);

    // In_Ready depends only on state, never on WB_Grant.
    assign In_Ready = !full;
    assign Count    = wr_ptr_q - rd_ptr_q;

    // Writes to register 0 complete the handshake but are dropped here.
    assign push = In_Valid && !full && (In_Addr != '0);
    assign pop  = !empty && WB_Grant;

    // Drain port
    always_comb begin
        WE3 = pop;
        A3  = '0;
        WD3 = '0;
        if (!empty) begin
            A3  = addr_q[rd_idx];
            WD3 = data_q[rd_idx];
        end
    end

    // Next-state pointers and valid bits
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (push) begin
            wr_ptr_d        = wr_ptr_q + 1'b1;
            valid_d[wr_idx] = 1'b1;
        end
        if (pop) begin
            rd_ptr_d        = rd_ptr_q + 1'b1;
            // push and pop never target the same slot: that would need full or empty
            valid_d[rd_idx] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < Queue_Depth; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            addr_q[wr_idx] <= In_Addr;
            data_q[wr_idx] <= In_Data;
        end
    end

    // Lookup: walk from oldest (head) to youngest so the last match wins.
    // Only stored entries are searched; the head still hits while it pops.
    logic [IdxW-1:0] lk_idx;

    always_comb begin
        LK_Hit1 = 1'b0;
        LK_Hit2 = 1'b0;
        LK_D1   = '0;
        LK_D2   = '0;
        lk_idx  = '0;
        for (int i = 0; i < Queue_Depth; i++) begin
            lk_idx = rd_idx + IdxW'(i);
            if (valid_q[lk_idx]) begin
                if ((LK_A1 != '0) && (addr_q[lk_idx] == LK_A1)) begin
                    LK_Hit1 = 1'b1;
                    LK_D1   = data_q[lk_idx];
                end
                if ((LK_A2 != '0) && (addr_q[lk_idx] == LK_A2)) begin
                    LK_Hit2 = 1'b1;
                    LK_D2   = data_q[lk_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

    logic        CLK;
    logic        RST;
    logic        In_Valid;
    logic        In_Ready;
    logic [4:0]  In_Addr;
    logic [31:0] In_Data;
    logic        WB_Grant;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [4:0]  LK_A1;
    logic [4:0]  LK_A2;
    logic        LK_Hit1;
    logic        LK_Hit2;
    logic [31:0] LK_D1;
    logic [31:0] LK_D2;
    logic [2:0]  Count;

    int n_cmp;
    int n_err;

    regfile_wb_queue #(
        .Address_Width       (5),
        .Register_File_Width (32),
        .Queue_Depth         (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .In_Addr  (In_Addr),
        .In_Data  (In_Data),
        .WB_Grant (WB_Grant),
        .WE3      (WE3),
        .A3       (A3),
        .WD3      (WD3),
        .LK_A1    (LK_A1),
        .LK_A2    (LK_A2),
        .LK_Hit1  (LK_Hit1),
        .LK_Hit2  (LK_Hit2),
        .LK_D1    (LK_D1),
        .LK_D2    (LK_D2),
        .Count    (Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs and checks happen at edge+1.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        RST      = 1'b0;
        In_Valid = 1'b0;
        In_Addr  = '0;
        In_Data  = '0;
        WB_Grant = 1'b1;
        LK_A1    = 5'd5;
        LK_A2    = 5'd0;
        #3;
        // Reset state, grant high on an empty queue
        check("rst_ready", In_Ready, 1);
        check("rst_we3", WE3, 0);
        check("rst_a3", A3, 0);
        check("rst_wd3", WD3, 0);
        check("rst_hit1", LK_Hit1, 0);
        check("rst_d1", LK_D1, 0);
        check("rst_count", Count, 0);
        tick();
        RST = 1'b1;
        tick();

        // T1: single push, drained next cycle
        In_Valid = 1'b1; In_Addr = 5'd5; In_Data = 32'hAAAA0001;
        tick();
        In_Valid = 1'b0;
        #1;
        check("t1_we3", WE3, 1);
        check("t1_a3", A3, 5);
        check("t1_wd3", WD3, 32'hAAAA0001);
        check("t1_count", Count, 1);
        check("t1_pop_hit", LK_Hit1, 1);
        check("t1_pop_d1", LK_D1, 32'hAAAA0001);
        tick();
        check("t1_we3_after", WE3, 0);
        check("t1_count_after", Count, 0);
        check("t1_a3_after", A3, 0);

        // T2: fill, refuse a 5th push, then drain in order
        WB_Grant = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            In_Valid = 1'b1; In_Addr = 5'(i); In_Data = 32'h100 + 32'(i);
            tick();
        end
        In_Addr = 5'd9; In_Data = 32'h999;
        #1;
        check("t2_count_full", Count, 4);
        check("t2_ready_full", In_Ready, 0);
        tick();
        check("t2_count_refused", Count, 4);
        WB_Grant = 1'b1;
        #1;
        check("t2_ready_pop", In_Ready, 0);
        check("t2_we3_1", WE3, 1);
        check("t2_a3_1", A3, 1);
        check("t2_wd3_1", WD3, 32'h101);
        tick();
        In_Valid = 1'b0;
        #1;
        check("t2_count_3", Count, 3);
        for (int i = 2; i <= 4; i++) begin
            check("t2_we3", WE3, 1);
            check("t2_a3", A3, 64'(i));
            check("t2_wd3", WD3, 64'h100 + 64'(i));
            tick();
        end
        check("t2_we3_empty", WE3, 0);
        check("t2_count_empty", Count, 0);

        // T3: youngest match for repeated writes to one register
        WB_Grant = 1'b0;
        LK_A1 = 5'd7; LK_A2 = 5'd3;
        In_Valid = 1'b1; In_Addr = 5'd7; In_Data = 32'h11;
        tick();
        In_Data = 32'h22;
        tick();
        In_Valid = 1'b0;
        #1;
        check("t3_hit1", LK_Hit1, 1);
        check("t3_d1", LK_D1, 32'h22);
        check("t3_miss2", LK_Hit2, 0);
        check("t3_miss_d2", LK_D2, 0);
        LK_A2 = 5'd7;
        WB_Grant = 1'b1;
        #1;
        check("t3_hit2", LK_Hit2, 1);
        check("t3_d2", LK_D2, 32'h22);
        check("t3_wd3_old", WD3, 32'h11);
        tick();
        WB_Grant = 1'b0;
        #1;
        check("t3_hit1_one", LK_Hit1, 1);
        check("t3_d1_one", LK_D1, 32'h22);
        check("t3_count_one", Count, 1);
        WB_Grant = 1'b1;
        tick();
        WB_Grant = 1'b0;
        #1;
        check("t3_hit1_none", LK_Hit1, 0);
        check("t3_d1_none", LK_D1, 0);

        // Youngest match across the index wrap (slots 3 then 0)
        In_Valid = 1'b1; In_Addr = 5'd7; In_Data = 32'h33;
        tick();
        In_Data = 32'h44;
        tick();
        In_Valid = 1'b0;
        #1;
        check("wrap_d1", LK_D1, 32'h44);
        check("wrap_head", WD3, 32'h33);
        WB_Grant = 1'b1;
        tick();
        tick();
        check("wrap_count", Count, 0);

        // T4: register 0 write is accepted and dropped
        LK_A1 = 5'd0;
        In_Valid = 1'b1; In_Addr = 5'd0; In_Data = 32'hFFFF;
        #1;
        check("t4_ready", In_Ready, 1);
        tick();
        In_Valid = 1'b0;
        #1;
        check("t4_count", Count, 0);
        check("t4_we3", WE3, 0);
        check("t4_hit1", LK_Hit1, 0);

        // T5: steady push+pop with one entry in flight
        WB_Grant = 1'b0;
        In_Valid = 1'b1; In_Addr = 5'd10; In_Data = 32'h500;
        tick();
        WB_Grant = 1'b1;
        for (int i = 0; i < 10; i++) begin
            In_Addr = 5'(11 + i); In_Data = 32'h501 + 32'(i);
            #1;
            check("t5_count", Count, 1);
            check("t5_we3", WE3, 1);
            check("t5_a3", A3, 64'(10 + i));
            check("t5_wd3", WD3, 64'h500 + 64'(i));
            tick();
        end
        In_Valid = 1'b0;
        #1;
        check("t5_last_wd3", WD3, 32'h50A);
        check("t5_last_count", Count, 1);
        tick();
        check("t5_drained", Count, 0);

        // T6: reset asserted mid-cycle with pending writes
        WB_Grant = 1'b0;
        LK_A1 = 5'd1;
        for (int i = 1; i <= 3; i++) begin
            In_Valid = 1'b1; In_Addr = 5'(i); In_Data = 32'h60 + 32'(i);
            tick();
        end
        In_Valid = 1'b0;
        WB_Grant = 1'b1;
        #1;
        check("t6_we3_pre", WE3, 1);
        check("t6_count_pre", Count, 3);
        #2;
        RST = 1'b0;
        #1;
        check("t6_we3_rst", WE3, 0);
        check("t6_count_rst", Count, 0);
        check("t6_hit1_rst", LK_Hit1, 0);
        tick();
        check("t6_we3_hold", WE3, 0);
        RST = 1'b1;
        tick();
        check("t6_we3_rel", WE3, 0);
        check("t6_count_rel", Count, 0);
        check("t6_a3_rel", A3, 0);
        tick();
        check("t6_we3_rel2", WE3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
